pwm_multi: RTL
==============

Name: pwm_multi

Overview:
Multi-channel successor to the single-channel pwm. One shared N-bit counter, advanced by the existing `step` strobe from pulse_generator, drives CHANNELS compare outputs. Each channel has a double-buffered duty register, loaded through a valid/ready write port and committed only at period boundaries, so no channel ever shows a glitched period. Adds a runtime-selectable center-aligned (up/down) counting mode.

Parameters:
- N, 8, counter and duty width in bits (range 2..16).
- CHANNELS, 4, number of PWM outputs (range 1..32).
- CW, $clog2(CHANNELS) (minimum 1), width of the channel index. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  block enable; low freezes the counter and forces outputs low.
- step  in  1  count-advance strobe; counter moves one count per clk with step=1.
- center  in  1  mode request (0 = edge-aligned, 1 = center-aligned); sampled at period boundary.
- wr_valid  in  1  duty write request.
- wr_ready  out  1  write accept; a write occurs when wr_valid && wr_ready.
- wr_chan  in  CW  target channel; values >= CHANNELS are accepted and discarded.
- wr_duty  in  N  new duty value.
- out  out  CHANNELS  PWM outputs, registered.
- period_start  out  1  one-cycle pulse on the first count of each period, registered.

Behaviour:
- Reset state (rst=1 at a clk edge): cnt=0, dir=up, mode=edge, all pending and active duty = 0, out=0, period_start=0, wr_ready=0.
- wr_ready is a register: 0 during reset, 1 from the first clk after rst deasserts, then stays 1. It is independent of ena.
- Write: an accepted write loads pending[wr_chan] <= wr_duty. A later write before the commit overwrites the earlier one.
- Advance condition: adv = ena && step. With adv=0, cnt, dir and mode hold.
- Edge mode: on adv, cnt goes 0..2^N-1 and wraps to 0. Period = 2^N advances.
- Center mode: on adv, cnt counts up 0..2^N-1, then down 2^N-2..0, with dir flipping at the ends. Period = 2*(2^N-1) advances. The value 2^N-1 is visited once per period; 0 is visited once per period.
- Boundary: an adv in which cnt goes to 0 (edge wrap, or center down-count reaching 0).
- At a boundary:
  - active[i] <= pending[i] for all i.
  - mode <= center.
  - dir <= up.
  - period_start pulses in the following cycle, aligned with out for cnt=0.
- Write coincident with a boundary: the commit copies the pre-write pending value. The new value lands in pending and commits at the next boundary.
- Compare: cmp[i] = (cnt < active[i]).
  - duty 0 gives constant 0.
  - duty 2^N-1 is high for all counts except 2^N-1 (never 100%, matching pwm).
- Outputs: out[i] <= ena ? cmp[i] : 0, registered. Latency is one clk from a cnt change to out.
- ena deassert: out goes to 0 on the next clk. The counter is frozen and no commits happen; writes are still accepted. On re-enable, counting resumes from the frozen cnt and dir.
- First period after reset: active = 0, so all outputs stay low until the first boundary commits pending.
- Reset mid-period: returns to the reset state on the next clk. Pending writes are lost.

Optional Feature:
- Macro: PWM_MULTI_STAGGER_EN.
- Defined: in edge mode, channel i compares ((cnt + i*OFF) mod 2^N) < active[i], with OFF = 2^N / CHANNELS (integer division). This spreads channel edges to reduce simultaneous switching current. Center mode is unaffected.
- Undefined: all channels compare against cnt directly and rise together at the boundary.

Decomposition:
- Package pwm_multi_pkg:
  - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;
  - typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;
  - function stagger_offset(N, CHANNELS).
- Sub-module pwm_channel, instantiated with a generate loop, one per channel. It contains:
  - the pending and active registers,
  - the write-select match on wr_chan,
  - the commit on a shared boundary strobe,
  - the compare and the registered out bit.
- Counter, dir/mode and the boundary strobe live in pwm_multi.

Test Plan (N=4, CHANNELS=4, step tied to 1, ena=1 unless stated):
1. Edge mode: write ch0 duty=5, wait for a boundary. out[0] is high for exactly 5 of every 16 clks, rising one clk after period_start's count 0. Write duty=0: out[0] stays low.
2. Center mode: set center=1, write ch1 duty=4. After the next boundary, out[1] is high for 7 of every 30 clks (cnt 0-3 up, 3-1 down), symmetric around the cnt=0 point.
3. Double-buffer: during period k write ch2 duty=3, then duty=10. Period k is unchanged. Period k+1 shows 10 high clks of 16. A write on the exact boundary cycle takes effect one period later.
4. Enable/disable: drop ena mid-period at cnt=7. All outs are 0 on the next clk and cnt holds at 7. Re-raise ena: counting resumes at 7 and period length is preserved.
5. Reset mid-operation: assert rst for 1 clk at cnt=9 with pending writes. Next cycle cnt=0, out=0, wr_ready=0, and ready returns to 1 one clk later. The next period is all low.
6. With PWM_MULTI_STAGGER_EN defined: all channels duty=8. Rising edges of out[0..3] occur at cnt 0, 12, 8, 4. Each channel is high for 8 clks per 16.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// Shared types and helpers for the multi-channel PWM.
// Optional build macro: PWM_MULTI_STAGGER_EN (per-channel phase stagger in edge mode).
package pwm_multi_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  // Phase spacing between adjacent channels when staggering is enabled.
  function automatic int stagger_offset(input int n, input int channels);
    return (1 << n) / channels;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty (pending/active), write select,
// period-boundary commit, compare against the shared counter and output register.
// Optional build macro: PWM_MULTI_STAGGER_EN shifts this channel's compare phase
// by IDX*OFF counts in edge mode.
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  parameter int CW       = 2,
  parameter int IDX      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          wr_fire,
  input  logic [CW-1:0] wr_chan,
  input  logic [N-1:0]  wr_duty,
  input  logic          commit,
  input  logic [N-1:0]  cnt,
  input  pwm_mode_t     mode,
  output logic          out
);

  localparam logic [CW-1:0] MY_CHAN = IDX[CW-1:0];

  logic [N-1:0] pending;
  logic [N-1:0] active;
  logic [N-1:0] cmp_cnt;
  logic         wr_hit;
  logic         cmp;

  // Out-of-range channel indices never match any instance, so such writes vanish.
  assign wr_hit = wr_fire && (wr_chan == MY_CHAN);

`ifdef PWM_MULTI_STAGGER_EN
  localparam int           SHIFT_I = (IDX * stagger_offset(N, CHANNELS)) % (1 << N);
  localparam logic [N-1:0] SHIFT   = SHIFT_I[N-1:0];
`else
  logic unused_mode;
  assign unused_mode = (mode == PWM_CENTER);
`endif

  // Compare: counter (optionally phase-shifted in edge mode) below the active duty.
  always_comb begin
    cmp_cnt = cnt;
`ifdef PWM_MULTI_STAGGER_EN
    if (mode == PWM_EDGE) begin
      cmp_cnt = cnt + SHIFT;
    end
`endif
    cmp = (cmp_cnt < active);
  end

  // Duty buffers and output register; a write on a commit cycle lands in pending
  // only, so the commit copies the value pending held before that write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
      out     <= 1'b0;
    end else begin
      if (wr_hit) begin
        pending <= wr_duty;
      end
      if (commit) begin
        active <= pending;
      end
      out <= ena && cmp;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared counter (edge or center-aligned) feeding
// CHANNELS double-buffered compare channels.
// Optional build macro: PWM_MULTI_STAGGER_EN (per-channel phase stagger in edge mode).
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                step,
  input  logic                center,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CW-1:0]       wr_chan,
  input  logic [N-1:0]        wr_duty,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nxt;
  pwm_dir_t     dir;
  pwm_dir_t     dir_nxt;
  pwm_mode_t    mode;
  logic         adv;
  logic         boundary;
  logic         bnd_p0;
  logic         wr_fire;

  assign adv     = ena && step;
  assign wr_fire = wr_valid && wr_ready;

  // Next count/direction; boundary flags the advance that lands on count 0.
  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (adv) begin
      if (mode == PWM_EDGE) begin
        cnt_nxt  = cnt + ONE;
        boundary = (cnt == CNT_MAX);
      end else if (dir == DIR_UP) begin
        if (cnt == CNT_MAX) begin
          cnt_nxt = cnt - ONE;
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end else begin
        cnt_nxt  = cnt - ONE;
        boundary = (cnt == ONE);
      end
    end
  end

  // Counter, direction and mode; mode changes only at a boundary so a period is
  // never split between the two counting schemes. period_start is delayed one
  // extra cycle so it lines up with the registered output for count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      mode         <= PWM_EDGE;
      bnd_p0       <= 1'b0;
      period_start <= 1'b0;
      wr_ready     <= 1'b0;
    end else begin
      wr_ready     <= 1'b1;
      cnt          <= cnt_nxt;
      bnd_p0       <= boundary;
      period_start <= bnd_p0;
      if (boundary) begin
        dir  <= DIR_UP;
        mode <= pwm_mode_t'(center);
      end else begin
        dir  <= dir_nxt;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_channel #(
      .N        (N),
      .CHANNELS (CHANNELS),
      .CW       (CW),
      .IDX      (g)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .wr_fire (wr_fire),
      .wr_chan (wr_chan),
      .wr_duty (wr_duty),
      .commit  (boundary),
      .cnt     (cnt),
      .mode    (mode),
      .out     (out[g])
    );
  end

endmodule
